control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main decoder for the single-issue LEGv8-style datapath.
- Takes the 11-bit instruction opcode field, the 4-bit branch condition field, the stored condition flags and the live ALU zero flag.
- Produces all datapath select and write-enable controls.
- Outputs are registered: one clock after the inputs are presented.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Cond  in  4  B.cond condition code, instruction bits [3:0].
- OpCode  in  11  instruction bits [31:21].
- FlagsR  in  2  stored flags: [1] = Z, [0] = N. C and V are not stored and are treated as 0.
- FlagsZ  in  1  live ALU zero flag, used by CBZ/CBNZ.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = PC + branch offset, 10 = register (BR).
- DMWr  out  1  data memory write enable.
- DMRd  out  1  data memory read enable.
- RFDataWrScr  out  2  register-file write data: 00 = ALU, 01 = memory, 10 = PC+4, 11 = SEU output.
- ALUOp  out  4  0000 AND, 0001 ORR, 0010 ADD, 0011 EOR, 0110 SUB, 0111 pass B, 1000 LSL, 1001 LSR.
- ALUBScr  out  1  ALU B operand: 0 = register read 2, 1 = SEU output.
- SEUScr  out  2  immediate format: 00 = 12-bit zero-extended ALU immediate, 01 = 9-bit signed D offset, 10 = 26-bit signed B offset, 11 = 19-bit signed CB offset.
- RFWr  out  1  register-file write enable.
- RegWrSrc  out  1  write register: 0 = Rd, 1 = X30.
- FlagsWr  out  1  flag register write enable.
- RegRd2Src  out  1  read port 2 address: 0 = Rm, 1 = Rt (bits [4:0]).

Behaviour:
- All outputs are flops updated every rising clk edge from the combinational decode of the current inputs. Latency is exactly 1 cycle; there is no other state.
- rst_n = 0 at a clock edge sets every output to 0 (NOP: PC+4, no writes). Reset dominates any opcode.
- Default: any field not listed below is 0. An unrecognised opcode decodes to all-zero (NOP).
- R-type: RFWr = 1, ALUBScr = 0.
  - ADD 10001011000: ALUOp 0010.
  - ADDS 10101011000: ALUOp 0010, FlagsWr = 1.
  - SUB 11001011000: ALUOp 0110.
  - SUBS 11101011000: ALUOp 0110, FlagsWr = 1.
  - AND 10001010000: ALUOp 0000.
  - ANDS 11101010000: ALUOp 0000, FlagsWr = 1.
  - ORR 10101010000: ALUOp 0001.
  - EOR 11001010000: ALUOp 0011.
  - LSL 11010011011: ALUOp 1000, ALUBScr = 1, SEUScr 00.
  - LSR 11010011010: ALUOp 1001, ALUBScr = 1, SEUScr 00.
- I-type (bit [0] is a don't-care): RFWr = 1, ALUBScr = 1, SEUScr 00.
  - ADDI 1001000100x: ALUOp 0010.
  - ADDIS 1011000100x: ALUOp 0010, FlagsWr = 1.
  - SUBI 1101000100x: ALUOp 0110.
  - SUBIS 1111000100x: ALUOp 0110, FlagsWr = 1.
  - ANDI 1001001000x: ALUOp 0000.
  - ANDIS 1111001000x: ALUOp 0000, FlagsWr = 1.
  - ORRI 1011001000x: ALUOp 0001.
  - EORI 1101001000x: ALUOp 0011.
- MOVZ 110100101xx: RFWr = 1, RFDataWrScr 11, SEUScr 00.
- LDUR 11111000010: DMRd = 1, RFWr = 1, RFDataWrScr 01, ALUOp 0010, ALUBScr = 1, SEUScr 01.
- STUR 11111000000: DMWr = 1, ALUOp 0010, ALUBScr = 1, SEUScr 01, RegRd2Src = 1.
- B 000101xxxxx: PCSrc 01, SEUScr 10.
- BL 100101xxxxx: PCSrc 01, SEUScr 10, RFWr = 1, RFDataWrScr 10, RegWrSrc = 1.
- BR 11010110000: PCSrc 10.
- CBZ / CBNZ (10110100xxx / 10110101xxx):
  - Common: SEUScr 11, ALUOp 0111, RegRd2Src = 1.
  - PCSrc 01 if FlagsZ = 1 (CBZ) or FlagsZ = 0 (CBNZ); otherwise 00.
- B.cond 01010100xxx: SEUScr 11. PCSrc 01 if the condition holds, else 00. Conditions (C = V = 0):
  - EQ Z; NE !Z.
  - HS 0; LO 1.
  - MI N; PL !N.
  - VS 0; VC 1.
  - HI 0; LS 1.
  - GE !N; LT N.
  - GT !Z & !N; LE Z | N.
  - AL 1; NV 1.
- Cond is ignored for every opcode other than B.cond. FlagsZ is ignored except for CBZ/CBNZ.

Test Plan:
- rst_n = 0 for 2 cycles with OpCode ANDIS -> all outputs 0. Release reset -> decode appears after the next edge.
- OpCode 11110010000 (ANDIS), Cond 0000, FlagsR 2, FlagsZ 0 -> after 1 edge:
  - ALUOp 0000, ALUBScr 1, SEUScr 00, RFWr 1, FlagsWr 1.
  - PCSrc 00, DMWr 0, DMRd 0, RFDataWrScr 00, RegWrSrc 0, RegRd2Src 0.
- LDUR then STUR on consecutive cycles -> correct DMRd/DMWr sequence, each one cycle late. STUR gives RegRd2Src 1, RFWr 0.
- B.cond with FlagsR 2 (Z = 1) -> Cond EQ gives PCSrc 01; Cond NE gives 00. FlagsR 1 (N = 1) with Cond LT gives 01; with GE gives 00.
- CBZ with FlagsZ 1 -> PCSrc 01; with FlagsZ 0 -> 00. CBNZ gives the inverse.
- BL -> PCSrc 01, RFWr 1, RFDataWrScr 10, RegWrSrc 1. Opcode 00000000000 -> all zero.

Source files
------------

// File: rtl/control_unit.sv
// ============================================================================
// control_unit
// ----------------------------------------------------------------------------
// Main decoder for the single-issue LEGv8-style datapath. The opcode, branch
// condition and flags are decoded combinationally and the result is captured
// in flops, so every control output appears one clock after its inputs.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   synchronous active-low reset (all outputs -> 0)
//   Cond         in   4   B.cond condition code (instruction bits [3:0])
//   OpCode       in  11   instruction bits [31:21]
//   FlagsR       in   2   stored flags, [1] = Z, [0] = N
//   FlagsZ       in   1   live ALU zero flag (CBZ / CBNZ)
//   PCSrc        out  2   00 PC+4, 01 PC+offset, 10 register (BR)
//   DMWr         out  1   data memory write enable
//   DMRd         out  1   data memory read enable
//   RFDataWrScr  out  2   00 ALU, 01 memory, 10 PC+4, 11 SEU
//   ALUOp        out  4   ALU operation select
//   ALUBScr      out  1   0 register read 2, 1 SEU output
//   SEUScr       out  2   00 imm12, 01 D offset, 10 B offset, 11 CB offset
//   RFWr         out  1   register-file write enable
//   RegWrSrc     out  1   0 Rd, 1 X30
//   FlagsWr      out  1   flag register write enable
//   RegRd2Src    out  1   0 Rm, 1 Rt
// ============================================================================
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  Cond,
    input  logic [10:0] OpCode,
    input  logic [1:0]  FlagsR,
    input  logic        FlagsZ,
    output logic [1:0]  PCSrc,
    output logic        DMWr,
    output logic        DMRd,
    output logic [1:0]  RFDataWrScr,
    output logic [3:0]  ALUOp,
    output logic        ALUBScr,
    output logic [1:0]  SEUScr,
    output logic        RFWr,
    output logic        RegWrSrc,
    output logic        FlagsWr,
    output logic        RegRd2Src
);

    logic       cond_true;
    logic [1:0] pcsrc_d;
    logic       dmwr_d;
    logic       dmrd_d;
    logic [1:0] rfdata_d;
    logic [3:0] aluop_d;
    logic       alub_d;
    logic [1:0] seu_d;
    logic       rfwr_d;
    logic       regwrsrc_d;
    logic       flagswr_d;
    logic       regrd2_d;

    // Evaluate the B.cond condition. Carry and overflow are never stored, so
    // every condition that depends on them collapses to a constant.
    always_comb begin
        cond_true = 1'b1;
        case (Cond)
            4'h0:    cond_true = FlagsR[1];                  // EQ
            4'h1:    cond_true = ~FlagsR[1];                 // NE
            4'h2:    cond_true = 1'b0;                       // HS
            4'h3:    cond_true = 1'b1;                       // LO
            4'h4:    cond_true = FlagsR[0];                  // MI
            4'h5:    cond_true = ~FlagsR[0];                 // PL
            4'h6:    cond_true = 1'b0;                       // VS
            4'h7:    cond_true = 1'b1;                       // VC
            4'h8:    cond_true = 1'b0;                       // HI
            4'h9:    cond_true = 1'b1;                       // LS
            4'hA:    cond_true = ~FlagsR[0];                 // GE
            4'hB:    cond_true = FlagsR[0];                  // LT
            4'hC:    cond_true = ~FlagsR[1] & ~FlagsR[0];    // GT
            4'hD:    cond_true = FlagsR[1] | FlagsR[0];      // LE
            default: cond_true = 1'b1;                       // AL, NV
        endcase
    end

    // Opcode decode. Everything defaults to the NOP encoding so unknown
    // opcodes fall through harmlessly.
    always_comb begin
        pcsrc_d    = 2'b00;
        dmwr_d     = 1'b0;
        dmrd_d     = 1'b0;
        rfdata_d   = 2'b00;
        aluop_d    = 4'b0000;
        alub_d     = 1'b0;
        seu_d      = 2'b00;
        rfwr_d     = 1'b0;
        regwrsrc_d = 1'b0;
        flagswr_d  = 1'b0;
        regrd2_d   = 1'b0;
        casez (OpCode)
            11'b10001011000: begin rfwr_d = 1'b1; aluop_d = 4'b0010; end
            11'b10101011000: begin rfwr_d = 1'b1; aluop_d = 4'b0010; flagswr_d = 1'b1; end
            11'b11001011000: begin rfwr_d = 1'b1; aluop_d = 4'b0110; end
            11'b11101011000: begin rfwr_d = 1'b1; aluop_d = 4'b0110; flagswr_d = 1'b1; end
            11'b10001010000: begin rfwr_d = 1'b1; aluop_d = 4'b0000; end
            11'b11101010000: begin rfwr_d = 1'b1; aluop_d = 4'b0000; flagswr_d = 1'b1; end
            11'b10101010000: begin rfwr_d = 1'b1; aluop_d = 4'b0001; end
            11'b11001010000: begin rfwr_d = 1'b1; aluop_d = 4'b0011; end
            11'b11010011011: begin rfwr_d = 1'b1; aluop_d = 4'b1000; alub_d = 1'b1; end
            11'b11010011010: begin rfwr_d = 1'b1; aluop_d = 4'b1001; alub_d = 1'b1; end
            11'b1001000100?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0010; end
            11'b1011000100?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0010; flagswr_d = 1'b1; end
            11'b1101000100?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0110; end
            11'b1111000100?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0110; flagswr_d = 1'b1; end
            11'b1001001000?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0000; end
            11'b1111001000?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0000; flagswr_d = 1'b1; end
            11'b1011001000?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0001; end
            11'b1101001000?: begin rfwr_d = 1'b1; alub_d = 1'b1; aluop_d = 4'b0011; end
            11'b110100101??: begin rfwr_d = 1'b1; rfdata_d = 2'b11; end
            11'b11111000010: begin
                dmrd_d   = 1'b1;
                rfwr_d   = 1'b1;
                rfdata_d = 2'b01;
                aluop_d  = 4'b0010;
                alub_d   = 1'b1;
                seu_d    = 2'b01;
            end
            11'b11111000000: begin
                dmwr_d   = 1'b1;
                aluop_d  = 4'b0010;
                alub_d   = 1'b1;
                seu_d    = 2'b01;
                regrd2_d = 1'b1;
            end
            11'b000101?????: begin pcsrc_d = 2'b01; seu_d = 2'b10; end
            11'b100101?????: begin
                pcsrc_d    = 2'b01;
                seu_d      = 2'b10;
                rfwr_d     = 1'b1;
                rfdata_d   = 2'b10;
                regwrsrc_d = 1'b1;
            end
            11'b11010110000: pcsrc_d = 2'b10;
            // CBZ and CBNZ differ only in bit 3: branch when the live zero
            // flag disagrees with that bit.
            11'b1011010????: begin
                seu_d    = 2'b11;
                aluop_d  = 4'b0111;
                regrd2_d = 1'b1;
                pcsrc_d  = {1'b0, FlagsZ ^ OpCode[3]};
            end
            11'b01010100???: begin
                seu_d   = 2'b11;
                pcsrc_d = {1'b0, cond_true};
            end
            default: ;
        endcase
    end

    // Output register: reset forces the NOP encoding regardless of opcode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PCSrc       <= 2'b00;
            DMWr        <= 1'b0;
            DMRd        <= 1'b0;
            RFDataWrScr <= 2'b00;
            ALUOp       <= 4'b0000;
            ALUBScr     <= 1'b0;
            SEUScr      <= 2'b00;
            RFWr        <= 1'b0;
            RegWrSrc    <= 1'b0;
            FlagsWr     <= 1'b0;
            RegRd2Src   <= 1'b0;
        end else begin
            PCSrc       <= pcsrc_d;
            DMWr        <= dmwr_d;
            DMRd        <= dmrd_d;
            RFDataWrScr <= rfdata_d;
            ALUOp       <= aluop_d;
            ALUBScr     <= alub_d;
            SEUScr      <= seu_d;
            RFWr        <= rfwr_d;
            RegWrSrc    <= regwrsrc_d;
            FlagsWr     <= flagswr_d;
            RegRd2Src   <= regrd2_d;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit
// ----------------------------------------------------------------------------
// Self-checking bench for control_unit. A behavioural reference decoder
// (instruction classes plus architectural condition evaluation) predicts the
// registered outputs; directed cases follow the test plan, then randomized
// opcodes / flags / resets are run through the same reference.
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  Cond;
    logic [10:0] OpCode;
    logic [1:0]  FlagsR;
    logic        FlagsZ;
    logic [1:0]  PCSrc;
    logic        DMWr;
    logic        DMRd;
    logic [1:0]  RFDataWrScr;
    logic [3:0]  ALUOp;
    logic        ALUBScr;
    logic [1:0]  SEUScr;
    logic        RFWr;
    logic        RegWrSrc;
    logic        FlagsWr;
    logic        RegRd2Src;

    int checkCount = 0;
    int failCount  = 0;

    logic [16:0] lastExpected;
    bit          haveLast = 0;

    localparam logic [10:0] BASES [27] = '{
        11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
        11'b10001010000, 11'b11101010000, 11'b10101010000, 11'b11001010000,
        11'b11010011011, 11'b11010011010,
        11'b10010001000, 11'b10110001000, 11'b11010001000, 11'b11110001000,
        11'b10010010000, 11'b11110010000, 11'b10110010000, 11'b11010010000,
        11'b11010010100, 11'b11111000010, 11'b11111000000,
        11'b00010100000, 11'b10010100000, 11'b11010110000,
        11'b10110100000, 11'b10110101000, 11'b01010100000
    };
    localparam int DCBITS [27] = '{
        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        1, 1, 1, 1, 1, 1, 1, 1,
        2, 0, 0,
        5, 5, 0,
        3, 3, 3
    };

    always #5 clk = ~clk;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Cond        (Cond),
        .OpCode      (OpCode),
        .FlagsR      (FlagsR),
        .FlagsZ      (FlagsZ),
        .PCSrc       (PCSrc),
        .DMWr        (DMWr),
        .DMRd        (DMRd),
        .RFDataWrScr (RFDataWrScr),
        .ALUOp       (ALUOp),
        .ALUBScr     (ALUBScr),
        .SEUScr      (SEUScr),
        .RFWr        (RFWr),
        .RegWrSrc    (RegWrSrc),
        .FlagsWr     (FlagsWr),
        .RegRd2Src   (RegRd2Src)
    );

    logic [16:0] dutVec;
    assign dutVec = {PCSrc, DMWr, DMRd, RFDataWrScr, ALUOp, ALUBScr, SEUScr,
                     RFWr, RegWrSrc, FlagsWr, RegRd2Src};

    // Opcode match ignoring the given number of low don't-care bits.
    function automatic bit isOp(input logic [10:0] op, input logic [10:0] val, input int dc);
        return (op >> dc) == (val >> dc);
    endfunction

    // Architectural condition evaluation with C = V = 0.
    function automatic bit condHolds(input logic [3:0] c, input logic [1:0] fr);
        bit z, n, cf, vf, r;
        z = fr[1]; n = fr[0]; cf = 0; vf = 0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = vf;
            3'd4: r = cf && !z;
            3'd5: r = (n == vf);
            3'd6: r = !z && (n == vf);
            default: r = 1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    // Reference decoder producing the packed control vector.
    function automatic logic [16:0] refDecode(input logic [10:0] op, input logic [3:0] c,
                                               input logic [1:0] fr, input logic fz);
        logic [1:0] pc, rfd, seu;
        logic [3:0] alu;
        logic dmwr, dmrd, alub, rfwr, rws, fwr, rr2;
        bit rType, iType, setsFlags;
        pc = 0; rfd = 0; seu = 0; alu = 0;
        dmwr = 0; dmrd = 0; alub = 0; rfwr = 0; rws = 0; fwr = 0; rr2 = 0;
        rType = 1; iType = 1; setsFlags = 0;
        if      (isOp(op, 11'b10001011000, 0)) alu = 4'b0010;
        else if (isOp(op, 11'b10101011000, 0)) begin alu = 4'b0010; setsFlags = 1; end
        else if (isOp(op, 11'b11001011000, 0)) alu = 4'b0110;
        else if (isOp(op, 11'b11101011000, 0)) begin alu = 4'b0110; setsFlags = 1; end
        else if (isOp(op, 11'b10001010000, 0)) alu = 4'b0000;
        else if (isOp(op, 11'b11101010000, 0)) begin alu = 4'b0000; setsFlags = 1; end
        else if (isOp(op, 11'b10101010000, 0)) alu = 4'b0001;
        else if (isOp(op, 11'b11001010000, 0)) alu = 4'b0011;
        else if (isOp(op, 11'b11010011011, 0)) begin alu = 4'b1000; alub = 1; end
        else if (isOp(op, 11'b11010011010, 0)) begin alu = 4'b1001; alub = 1; end
        else rType = 0;
        if      (isOp(op, 11'b10010001000, 1)) alu = 4'b0010;
        else if (isOp(op, 11'b10110001000, 1)) begin alu = 4'b0010; setsFlags = 1; end
        else if (isOp(op, 11'b11010001000, 1)) alu = 4'b0110;
        else if (isOp(op, 11'b11110001000, 1)) begin alu = 4'b0110; setsFlags = 1; end
        else if (isOp(op, 11'b10010010000, 1)) alu = 4'b0000;
        else if (isOp(op, 11'b11110010000, 1)) begin alu = 4'b0000; setsFlags = 1; end
        else if (isOp(op, 11'b10110010000, 1)) alu = 4'b0001;
        else if (isOp(op, 11'b11010010000, 1)) alu = 4'b0011;
        else iType = 0;
        if (rType || iType) begin
            rfwr = 1;
            fwr  = setsFlags;
            if (iType) alub = 1;
        end else if (isOp(op, 11'b11010010100, 2)) begin
            rfwr = 1; rfd = 2'b11;
        end else if (isOp(op, 11'b11111000010, 0)) begin
            dmrd = 1; rfwr = 1; rfd = 2'b01; alu = 4'b0010; alub = 1; seu = 2'b01;
        end else if (isOp(op, 11'b11111000000, 0)) begin
            dmwr = 1; alu = 4'b0010; alub = 1; seu = 2'b01; rr2 = 1;
        end else if (isOp(op, 11'b00010100000, 5)) begin
            pc = 2'b01; seu = 2'b10;
        end else if (isOp(op, 11'b10010100000, 5)) begin
            pc = 2'b01; seu = 2'b10; rfwr = 1; rfd = 2'b10; rws = 1;
        end else if (isOp(op, 11'b11010110000, 0)) begin
            pc = 2'b10;
        end else if (isOp(op, 11'b10110100000, 3)) begin
            seu = 2'b11; alu = 4'b0111; rr2 = 1; pc = fz ? 2'b01 : 2'b00;
        end else if (isOp(op, 11'b10110101000, 3)) begin
            seu = 2'b11; alu = 4'b0111; rr2 = 1; pc = fz ? 2'b00 : 2'b01;
        end else if (isOp(op, 11'b01010100000, 3)) begin
            seu = 2'b11; pc = condHolds(c, fr) ? 2'b01 : 2'b00;
        end
        return {pc, dmwr, dmrd, rfd, alu, alub, seu, rfwr, rws, fwr, rr2};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] observed,
                               input logic [16:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs between edges, confirm the outputs have not
    // moved yet, then check the registered decode after the rising edge.
    task automatic applyStimulus(input string tag, input logic rstN, input logic [10:0] op,
                                 input logic [3:0] c, input logic [1:0] fr, input logic fz);
        logic [16:0] expected;
        @(negedge clk);
        rst_n = rstN; OpCode = op; Cond = c; FlagsR = fr; FlagsZ = fz;
        #1;
        if (haveLast) checkOutput({tag, "_hold"}, dutVec, lastExpected);
        expected = rstN ? refDecode(op, c, fr, fz) : 17'd0;
        @(posedge clk);
        #1;
        checkOutput(tag, dutVec, expected);
        lastExpected = expected;
        haveLast     = 1;
    endtask

    // Directed test plan followed by randomized decode.
    initial begin
        logic [10:0] op;
        logic [10:0] dcMask;
        int          k;
        rst_n = 1'b0; OpCode = 11'b11110010000; Cond = 4'h0; FlagsR = 2'd2; FlagsZ = 1'b0;

        applyStimulus("reset0", 1'b0, 11'b11110010000, 4'h0, 2'd2, 1'b0);
        applyStimulus("reset1", 1'b0, 11'b11110010000, 4'h0, 2'd2, 1'b0);
        applyStimulus("andis", 1'b1, 11'b11110010000, 4'h0, 2'd2, 1'b0);
        checkOutput("andis_vec", dutVec, 17'b00_0_0_00_0000_1_00_1_0_1_0);

        applyStimulus("ldur", 1'b1, 11'b11111000010, 4'h0, 2'd0, 1'b0);
        checkOutput("ldur_dmrd", {15'd0, DMRd, DMWr}, 17'b10);
        applyStimulus("stur", 1'b1, 11'b11111000000, 4'h0, 2'd0, 1'b0);
        checkOutput("stur_vec", {14'd0, DMWr, RegRd2Src, RFWr}, 17'b110);

        applyStimulus("bcond_eq", 1'b1, 11'b01010100000, 4'h0, 2'd2, 1'b0);
        checkOutput("bcond_eq_pc", {15'd0, PCSrc}, 17'd1);
        applyStimulus("bcond_ne", 1'b1, 11'b01010100101, 4'h1, 2'd2, 1'b0);
        checkOutput("bcond_ne_pc", {15'd0, PCSrc}, 17'd0);
        applyStimulus("bcond_lt", 1'b1, 11'b01010100010, 4'hB, 2'd1, 1'b0);
        applyStimulus("bcond_ge", 1'b1, 11'b01010100111, 4'hA, 2'd1, 1'b0);
        applyStimulus("cbz_t", 1'b1, 11'b10110100011, 4'h5, 2'd0, 1'b1);
        applyStimulus("cbz_f", 1'b1, 11'b10110100000, 4'h5, 2'd0, 1'b0);
        applyStimulus("cbnz_t", 1'b1, 11'b10110101000, 4'h0, 2'd3, 1'b0);
        applyStimulus("cbnz_f", 1'b1, 11'b10110101111, 4'h0, 2'd3, 1'b1);
        applyStimulus("bl", 1'b1, 11'b10010111010, 4'h0, 2'd0, 1'b0);
        checkOutput("bl_vec", dutVec, 17'b01_0_0_10_0000_0_10_1_1_0_0);
        applyStimulus("zero_op", 1'b1, 11'b00000000000, 4'hF, 2'd3, 1'b1);
        checkOutput("zero_op_vec", dutVec, 17'd0);
        applyStimulus("reset_mid", 1'b0, 11'b10010111010, 4'h0, 2'd0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 11'($urandom);
            end else begin
                k      = $urandom_range(0, 26);
                dcMask = (11'd1 << DCBITS[k]) - 11'd1;
                op     = BASES[k] | (11'($urandom) & dcMask);
            end
            applyStimulus("rand", ($urandom_range(0, 15) != 0), op,
                          4'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
